// File: rtl/ga_term_monitor_if.sv
// ---------------------------------------------------------------------------
// ga_term_monitor_if
// Candidate stream from the GA core into the termination monitor. Each
// steady-state slot the core presents one {chromosome, fitness} pair,
// qualified by in_valid.
//   master : GA core side (drives the sample)
//   slave  : termination monitor side (consumes the sample)
// ---------------------------------------------------------------------------
interface ga_term_monitor_if #(
    parameter int CHROM_W = 8,
    parameter int FIT_W   = 27
);
    logic                      in_valid;
    logic [CHROM_W-1:0]        in_chrom;
    logic signed [FIT_W-1:0]   in_fit;

    modport master (
        output in_valid,
        output in_chrom,
        output in_fit
    );

    modport slave (
        input  in_valid,
        input  in_chrom,
        input  in_fit
    );
endinterface

// File: rtl/ga_term_monitor.sv
// ---------------------------------------------------------------------------
// ga_term_monitor
// Termination monitor downstream of the GA core. Tracks the global best
// {chromosome, fitness}, counts samples into generations of GEN_SIZE,
// counts consecutive non-improving generations, and raises a sticky done
// (with a cause code) that the GA core uses to stop.
//
// Optional feature macro: GA_TERM_TARGET_EN
//   defined   : adds the signed target_fit input; any accepted sample whose
//               post-update best fitness reaches target_fit stops the run
//               immediately with cause 11.
//   undefined : no target_fit port; only MAX_GEN (01) / stall (10) stop.
//
// Reset is synchronous, active-low, and overrides any sample in that cycle.
// All outputs come straight from registers (one cycle after the sample).
// ---------------------------------------------------------------------------
module ga_term_monitor #(
    parameter int CHROM_W     = 8,
    parameter int FIT_W       = 27,
    parameter int GEN_SIZE    = 4,
    parameter int MAX_GEN     = 1024,
    parameter int STALL_LIMIT = 64
) (
    input  logic                                 clk,
    input  logic                                 reset,
    ga_term_monitor_if.slave                     smp,
`ifdef GA_TERM_TARGET_EN
    input  logic signed [FIT_W-1:0]              target_fit,
`endif
    output logic [CHROM_W-1:0]                   best_chrom,
    output logic signed [FIT_W-1:0]              best_fit,
    output logic                                 improved,
    output logic [$clog2(MAX_GEN+1)-1:0]         gen_count,
    output logic [$clog2(STALL_LIMIT+1)-1:0]     stall_count,
    output logic                                 done,
    output logic [1:0]                           done_cause
);

    // -----------------------------------------------------------------------
    // Derived widths and constants
    // -----------------------------------------------------------------------
    localparam int GEN_W   = $clog2(MAX_GEN + 1);
    localparam int STALL_W = $clog2(STALL_LIMIT + 1);
    localparam int SLOT_W  = (GEN_SIZE > 1) ? $clog2(GEN_SIZE) : 1;

    localparam logic [SLOT_W-1:0]  SLOT_LAST   = SLOT_W'(GEN_SIZE - 1);
    localparam logic [GEN_W-1:0]   GEN_LIMIT   = GEN_W'(MAX_GEN);
    localparam logic [STALL_W-1:0] STALL_MAX   = STALL_W'(STALL_LIMIT);

    // Most-negative fitness: any real sample beats the reset best.
    localparam logic signed [FIT_W-1:0] FIT_MIN = {1'b1, {(FIT_W-1){1'b0}}};

    // FSM encoding
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // Termination cause codes
    localparam logic [1:0] CAUSE_NONE   = 2'b00;
    localparam logic [1:0] CAUSE_GEN    = 2'b01;
    localparam logic [1:0] CAUSE_STALL  = 2'b10;
    localparam logic [1:0] CAUSE_TARGET = 2'b11;

    // -----------------------------------------------------------------------
    // Helpers
    // -----------------------------------------------------------------------
    // Strict signed comparison: ties keep the incumbent best.
    function automatic logic fit_gt(input logic signed [FIT_W-1:0] a,
                                    input logic signed [FIT_W-1:0] b);
        return (a > b);
    endfunction

    // Signed greater-or-equal, used for the target threshold.
    function automatic logic fit_ge(input logic signed [FIT_W-1:0] a,
                                    input logic signed [FIT_W-1:0] b);
        return (a >= b);
    endfunction

    // -----------------------------------------------------------------------
    // State registers
    // -----------------------------------------------------------------------
    logic [1:0]               state_r;
    logic [CHROM_W-1:0]       best_chrom_r;
    logic signed [FIT_W-1:0]  best_fit_r;
    logic                     improved_r;
    logic [GEN_W-1:0]         gen_count_r;
    logic [STALL_W-1:0]       stall_count_r;
    logic                     done_r;
    logic [1:0]               done_cause_r;
    logic [SLOT_W-1:0]        slot_r;
    logic                     gen_imp_r;

    // Next-state values
    logic [1:0]               state_s;
    logic [CHROM_W-1:0]       best_chrom_s;
    logic signed [FIT_W-1:0]  best_fit_s;
    logic                     improved_s;
    logic [GEN_W-1:0]         gen_count_s;
    logic [STALL_W-1:0]       stall_count_s;
    logic                     done_s;
    logic [1:0]               done_cause_s;
    logic [SLOT_W-1:0]        slot_s;
    logic                     gen_imp_s;

    // Per-cycle decode
    logic                     accept_s;
    logic                     replace_s;
    logic                     close_s;
    logic                     target_hit_s;

    // Sample acceptance and best-replacement decision
    always_comb begin
        accept_s  = smp.in_valid && (state_r != ST_DONE);
        replace_s = 1'b0;
        if (accept_s) begin
            // The first sample after reset is loaded unconditionally.
            if (state_r == ST_IDLE) begin
                replace_s = 1'b1;
            end else begin
                replace_s = fit_gt(smp.in_fit, best_fit_r);
            end
        end else begin
            replace_s = 1'b0;
        end
    end

    // Best tracking, slot/generation/stall bookkeeping and termination
    always_comb begin
        state_s       = state_r;
        best_chrom_s  = best_chrom_r;
        best_fit_s    = best_fit_r;
        improved_s    = 1'b0;
        gen_count_s   = gen_count_r;
        stall_count_s = stall_count_r;
        done_s        = done_r;
        done_cause_s  = done_cause_r;
        slot_s        = slot_r;
        gen_imp_s     = gen_imp_r;
        close_s       = 1'b0;
        target_hit_s  = 1'b0;

        if (accept_s) begin
            // Best replacement
            if (replace_s) begin
                best_chrom_s = smp.in_chrom;
                best_fit_s   = smp.in_fit;
                improved_s   = 1'b1;
            end else begin
                improved_s   = 1'b0;
            end

            // IDLE leaves on the first accepted sample
            case (state_r)
                ST_IDLE: state_s = ST_RUN;
                ST_RUN:  state_s = ST_RUN;
                default: state_s = state_r;
            endcase

            // Slot counter; the last slot closes the generation
            if (slot_r == SLOT_LAST) begin
                close_s     = 1'b1;
                slot_s      = SLOT_W'(0);
                gen_count_s = gen_count_r + GEN_W'(1);
                if (gen_imp_r || replace_s) begin
                    stall_count_s = STALL_W'(0);
                end else begin
                    stall_count_s = stall_count_r + STALL_W'(1);
                end
                gen_imp_s   = 1'b0;
            end else begin
                close_s     = 1'b0;
                slot_s      = slot_r + SLOT_W'(1);
                gen_imp_s   = gen_imp_r | replace_s;
            end

`ifdef GA_TERM_TARGET_EN
            target_hit_s = fit_ge(best_fit_s, target_fit);
`else
            target_hit_s = 1'b0;
`endif

            // Termination, highest priority first, on post-update values
            if (target_hit_s) begin
                state_s      = ST_DONE;
                done_s       = 1'b1;
                done_cause_s = CAUSE_TARGET;
            end else if (close_s && (stall_count_s == STALL_MAX)) begin
                state_s      = ST_DONE;
                done_s       = 1'b1;
                done_cause_s = CAUSE_STALL;
            end else if (close_s && (gen_count_s == GEN_LIMIT)) begin
                state_s      = ST_DONE;
                done_s       = 1'b1;
                done_cause_s = CAUSE_GEN;
            end else begin
                done_s       = done_r;
                done_cause_s = done_cause_r;
            end
        end else begin
            improved_s = 1'b0;
        end
    end

    // Register update with synchronous active-low reset overriding everything
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r       <= ST_IDLE;
            best_chrom_r  <= {CHROM_W{1'b0}};
            best_fit_r    <= FIT_MIN;
            improved_r    <= 1'b0;
            gen_count_r   <= GEN_W'(0);
            stall_count_r <= STALL_W'(0);
            done_r        <= 1'b0;
            done_cause_r  <= CAUSE_NONE;
            slot_r        <= SLOT_W'(0);
            gen_imp_r     <= 1'b0;
        end else begin
            state_r       <= state_s;
            best_chrom_r  <= best_chrom_s;
            best_fit_r    <= best_fit_s;
            improved_r    <= improved_s;
            gen_count_r   <= gen_count_s;
            stall_count_r <= stall_count_s;
            done_r        <= done_s;
            done_cause_r  <= done_cause_s;
            slot_r        <= slot_s;
            gen_imp_r     <= gen_imp_s;
        end
    end

    // Outputs are driven directly from state registers
    assign best_chrom  = best_chrom_r;
    assign best_fit    = best_fit_r;
    assign improved    = improved_r;
    assign gen_count   = gen_count_r;
    assign stall_count = stall_count_r;
    assign done        = done_r;
    assign done_cause  = done_cause_r;

endmodule

// File: tb/tb_ga_term_monitor.sv
// ---------------------------------------------------------------------------
// tb_ga_term_monitor
// Directed bench for ga_term_monitor. Three instances share one sample bus:
//   A : GEN_SIZE=4, MAX_GEN=8, STALL_LIMIT=2
//   B : GEN_SIZE=4, MAX_GEN=3, STALL_LIMIT=64
//   C : GEN_SIZE=1, MAX_GEN=3, STALL_LIMIT=2
// Expected values are hand-computed for each directed step.
// ---------------------------------------------------------------------------
module tb_ga_term_monitor;

    logic clk = 1'b0;
    logic reset;

    // Free-running clock, 10 time-unit period
    always #5 clk = ~clk;

    ga_term_monitor_if #(.CHROM_W(8), .FIT_W(27)) bus ();

`ifdef GA_TERM_TARGET_EN
    logic signed [26:0] target_fit;
`endif

    logic [7:0]         a_best_chrom, b_best_chrom, c_best_chrom;
    logic signed [26:0] a_best_fit,   b_best_fit,   c_best_fit;
    logic               a_improved,   b_improved,   c_improved;
    logic [3:0]         a_gen_count;
    logic [1:0]         b_gen_count,  c_gen_count;
    logic [1:0]         a_stall_count, c_stall_count;
    logic [6:0]         b_stall_count;
    logic               a_done,       b_done,       c_done;
    logic [1:0]         a_done_cause, b_done_cause, c_done_cause;

    ga_term_monitor #(.CHROM_W(8), .FIT_W(27), .GEN_SIZE(4), .MAX_GEN(8), .STALL_LIMIT(2)) dut_a (
        .clk(clk), .reset(reset), .smp(bus.slave),
`ifdef GA_TERM_TARGET_EN
        .target_fit(target_fit),
`endif
        .best_chrom(a_best_chrom), .best_fit(a_best_fit), .improved(a_improved),
        .gen_count(a_gen_count), .stall_count(a_stall_count),
        .done(a_done), .done_cause(a_done_cause)
    );

    ga_term_monitor #(.CHROM_W(8), .FIT_W(27), .GEN_SIZE(4), .MAX_GEN(3), .STALL_LIMIT(64)) dut_b (
        .clk(clk), .reset(reset), .smp(bus.slave),
`ifdef GA_TERM_TARGET_EN
        .target_fit(target_fit),
`endif
        .best_chrom(b_best_chrom), .best_fit(b_best_fit), .improved(b_improved),
        .gen_count(b_gen_count), .stall_count(b_stall_count),
        .done(b_done), .done_cause(b_done_cause)
    );

    ga_term_monitor #(.CHROM_W(8), .FIT_W(27), .GEN_SIZE(1), .MAX_GEN(3), .STALL_LIMIT(2)) dut_c (
        .clk(clk), .reset(reset), .smp(bus.slave),
`ifdef GA_TERM_TARGET_EN
        .target_fit(target_fit),
`endif
        .best_chrom(c_best_chrom), .best_fit(c_best_fit), .improved(c_improved),
        .gen_count(c_gen_count), .stall_count(c_stall_count),
        .done(c_done), .done_cause(c_done_cause)
    );

    int checks = 0;
    int errors = 0;

    // Compare one observed value against its expected value
    task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Advance one clock; land 1 time unit after the rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One valid sample for one cycle
    task automatic send(input logic [7:0] c, input logic signed [26:0] f);
        bus.in_valid = 1'b1;
        bus.in_chrom = c;
        bus.in_fit   = f;
        tick();
        bus.in_valid = 1'b0;
    endtask

    // One-cycle synchronous reset
    task automatic do_reset();
        reset = 1'b0;
        tick();
        reset = 1'b1;
    endtask

    // Check all outputs of instance A against reset values
    task automatic chk_a_reset(input string tag);
        chk({tag, "_a_chrom"}, a_best_chrom, 64'sd0);
        chk({tag, "_a_fit"},   a_best_fit,   -64'sd67108864);
        chk({tag, "_a_imp"},   a_improved,   64'sd0);
        chk({tag, "_a_gen"},   a_gen_count,  64'sd0);
        chk({tag, "_a_stall"}, a_stall_count, 64'sd0);
        chk({tag, "_a_done"},  a_done,       64'sd0);
        chk({tag, "_a_cause"}, a_done_cause, 64'sd0);
    endtask

    initial begin
        reset        = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_chrom = 8'h00;
        bus.in_fit   = 27'sd0;
`ifdef GA_TERM_TARGET_EN
        target_fit   = 27'sh3FFFFFF;
`endif

        // ---- 1: reset beats a simultaneous valid; first sample loads ----
        reset        = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_chrom = 8'hAA;
        bus.in_fit   = 27'sd5;
        tick();
        chk_a_reset("t1_rst");
        bus.in_valid = 1'b0;
        reset        = 1'b1;
        tick();
        chk("t1_idle_fit", a_best_fit, -64'sd67108864);
        send(8'h11, -27'sd7);
        chk("t1_fit",   a_best_fit,   -64'sd7);
        chk("t1_chrom", a_best_chrom, 64'sd17);
        chk("t1_imp",   a_improved,   64'sd1);
        chk("t1_gen",   a_gen_count,  64'sd0);
        chk("t1_c_gen", c_gen_count,  64'sd1);
        tick();
        chk("t1_imp_low", a_improved, 64'sd0);

        // ---- 2: fits 3,9,9,2; tie keeps the first 9 ----
        do_reset();
        send(8'h01, 27'sd3);
        chk("t2_imp1", a_improved, 64'sd1);
        send(8'h02, 27'sd9);
        chk("t2_imp2", a_improved, 64'sd1);
        send(8'h03, 27'sd9);
        chk("t2_imp3", a_improved, 64'sd0);
        chk("t2_tie_chrom", a_best_chrom, 64'sd2);
        send(8'h04, 27'sd2);
        chk("t2_fit",   a_best_fit,    64'sd9);
        chk("t2_chrom", a_best_chrom,  64'sd2);
        chk("t2_gen",   a_gen_count,   64'sd1);
        chk("t2_stall", a_stall_count, 64'sd0);
        chk("t2_done",  a_done,        64'sd0);

        // ---- 3: stall termination (A), priority stall>MAX_GEN (C) ----
        do_reset();
        send(8'h10, 27'sd10);
        chk("t3_c_gen1",   c_gen_count,   64'sd1);
        chk("t3_c_stall1", c_stall_count, 64'sd0);
        send(8'h20, 27'sd1);
        chk("t3_c_stall2", c_stall_count, 64'sd1);
        chk("t3_c_done2",  c_done,        64'sd0);
        send(8'h20, 27'sd1);
        chk("t3_c_done",   c_done,        64'sd1);
        chk("t3_c_cause",  c_done_cause,  64'sd2);
        chk("t3_c_gen",    c_gen_count,   64'sd3);
        for (int i = 4; i <= 8; i++) send(8'h20, 27'sd1);
        chk("t3_a_gen2",   a_gen_count,   64'sd2);
        chk("t3_a_stall1", a_stall_count, 64'sd1);
        for (int i = 9; i <= 11; i++) send(8'h20, 27'sd1);
        chk("t3_a_done11", a_done,        64'sd0);
        send(8'h20, 27'sd1);
        chk("t3_a_done",   a_done,        64'sd1);
        chk("t3_a_cause",  a_done_cause,  64'sd2);
        chk("t3_a_stall",  a_stall_count, 64'sd2);
        chk("t3_a_gen",    a_gen_count,   64'sd3);
        chk("t3_b_cause",  b_done_cause,  64'sd1);
        chk("t3_b_stall",  b_stall_count, 64'sd2);
        send(8'hFF, 27'sd50);
        chk("t3_ign_fit",  a_best_fit,    64'sd10);
        chk("t3_ign_imp",  a_improved,    64'sd0);
        chk("t3_ign_gen",  a_gen_count,   64'sd3);
        chk("t3_ign_cfit", c_best_fit,    64'sd10);

        // ---- 4: MAX_GEN termination with ascending fits (B) ----
        do_reset();
        for (int i = 1; i <= 11; i++) send(8'(i), 27'(i));
        chk("t4_b_done11", b_done,      64'sd0);
        chk("t4_b_gen11",  b_gen_count, 64'sd2);
        send(8'd12, 27'sd12);
        chk("t4_b_done",  b_done,        64'sd1);
        chk("t4_b_cause", b_done_cause,  64'sd1);
        chk("t4_b_gen",   b_gen_count,   64'sd3);
        chk("t4_b_stall", b_stall_count, 64'sd0);
        chk("t4_b_fit",   b_best_fit,    64'sd12);
        chk("t4_a_gen",   a_gen_count,   64'sd3);
        chk("t4_a_done",  a_done,        64'sd0);

        // ---- 6: reset while B is done and A is mid-generation ----
        send(8'd13, 27'sd13);
        send(8'd14, 27'sd14);
        chk("t6_b_frozen", b_best_fit, 64'sd12);
        reset        = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_chrom = 8'h55;
        bus.in_fit   = 27'sd5;
        tick();
        chk_a_reset("t6_rst");
        chk("t6_b_done",  b_done,       64'sd0);
        chk("t6_b_cause", b_done_cause, 64'sd0);
        chk("t6_b_fit",   b_best_fit,   -64'sd67108864);
        bus.in_valid = 1'b0;
        reset        = 1'b1;
        tick();
        send(8'h33, -27'sd3);
        chk("t6_a_fit", a_best_fit, -64'sd3);
        chk("t6_a_imp", a_improved, 64'sd1);
        chk("t6_b_fit2", b_best_fit, -64'sd3);
        send(8'h34, -27'sd3);
        send(8'h35, -27'sd3);
        chk("t6_a_gen3", a_gen_count, 64'sd0);
        send(8'h36, -27'sd3);
        chk("t6_a_gen4", a_gen_count, 64'sd1);

`ifdef GA_TERM_TARGET_EN
        // ---- 5: target termination, and priority over MAX_GEN ----
        target_fit = 27'sd100;
        do_reset();
        send(8'h05, 27'sd7);
        chk("t5_b_done0", b_done, 64'sd0);
        send(8'h06, 27'sd100);
        chk("t5_b_done",  b_done,       64'sd1);
        chk("t5_b_cause", b_done_cause, 64'sd3);
        chk("t5_b_gen",   b_gen_count,  64'sd0);
        do_reset();
        for (int i = 1; i <= 11; i++) send(8'(i), 27'(i));
        chk("t5_b_nohit", b_done, 64'sd0);
        send(8'h0C, 27'sd100);
        chk("t5_b_prio",     b_done_cause, 64'sd3);
        chk("t5_b_prio_gen", b_gen_count,  64'sd3);
        target_fit = 27'sh3FFFFFF;
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
